// File: rtl/seletor_aprovados_if.sv
// Evaluator/downstream bundle for seletor_aprovados. The master side is the
// selector; the slave side is the evaluator plus the record consumer.
interface seletor_aprovados_if #(
    parameter int NUM_ATIVOS = 24,
    parameter int NODE_WIDTH = 8,
    parameter int DIST_WIDTH = 8
);
    logic                             tem_ativo_in;
    logic [NUM_ATIVOS-1:0]            aprovados_in;
    logic [NUM_ATIVOS*NODE_WIDTH-1:0] enderecos_in;
    logic                             ler_distancia_out;
    logic [NODE_WIDTH-1:0]            ler_distancia_endereco_out;
    logic [DIST_WIDTH-1:0]            distancia_in;
    logic                             remover_out;
    logic [NODE_WIDTH-1:0]            remover_endereco_out;
    logic                             estab_valid_out;
    logic                             estab_ready_in;
    logic [NODE_WIDTH-1:0]            estab_endereco_out;
    logic [DIST_WIDTH-1:0]            estab_distancia_out;
    logic                             ocupado_out;
    logic                             rodada_fim_out;
    logic [NODE_WIDTH-1:0]            num_estab_out;

    modport master (
        input  tem_ativo_in, aprovados_in, enderecos_in, distancia_in, estab_ready_in,
        output ler_distancia_out, ler_distancia_endereco_out,
        output remover_out, remover_endereco_out,
        output estab_valid_out, estab_endereco_out, estab_distancia_out,
        output ocupado_out, rodada_fim_out, num_estab_out
    );

    modport slave (
        output tem_ativo_in, aprovados_in, enderecos_in, distancia_in, estab_ready_in,
        input  ler_distancia_out, ler_distancia_endereco_out,
        input  remover_out, remover_endereco_out,
        input  estab_valid_out, estab_endereco_out, estab_distancia_out,
        input  ocupado_out, rodada_fim_out, num_estab_out
    );
endinterface

// File: rtl/seletor_aprovados.sv
// Walks a snapshot of the approved-slot mask in ascending order: reads each
// node's distance, emits it as an established record, then asks for its removal.
module seletor_aprovados #(
    parameter int NUM_ATIVOS = 24,
    parameter int NODE_WIDTH = 8,
    parameter int DIST_WIDTH = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    seletor_aprovados_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        SELECIONAR,
        LER,
        ESPERA,
        ENVIAR,
        REMOVER
    } estado_t;

    estado_t                 estado, estado_n;
    logic [NUM_ATIVOS-1:0]   mascara, mascara_n;
    logic [NODE_WIDTH-1:0]   endereco_q, endereco_n;
    logic [DIST_WIDTH-1:0]   distancia_q, distancia_n;
    logic [NODE_WIDTH-1:0]   contador_q, contador_n;
    logic                    ler_q, ler_n;
    logic                    remover_q, remover_n;
    logic                    valid_q, valid_n;
    logic                    ocupado_q, ocupado_n;
    logic                    rodada_q, rodada_n;

    logic [NUM_ATIVOS-1:0]   bit_menor;
    logic [NODE_WIDTH-1:0]   endereco_sel;

    // Isolate the lowest set bit, then mux the matching slot address.
    always_comb begin
        bit_menor    = mascara & (~mascara + 1'b1);
        endereco_sel = '0;
        for (int unsigned i = 0; i < NUM_ATIVOS; i++) begin
            if (bit_menor[i]) begin
                endereco_sel = bus.enderecos_in[i*NODE_WIDTH +: NODE_WIDTH];
            end
        end
    end

    always_comb begin
        estado_n    = estado;
        mascara_n   = mascara;
        endereco_n  = endereco_q;
        distancia_n = distancia_q;
        contador_n  = contador_q;
        ler_n       = 1'b0;
        remover_n   = 1'b0;
        valid_n     = 1'b0;
        rodada_n    = 1'b0;

        unique case (estado)
            IDLE: begin
                if (bus.tem_ativo_in && (|bus.aprovados_in)) begin
                    mascara_n = bus.aprovados_in;
                    estado_n  = SELECIONAR;
                end
            end
            SELECIONAR: begin
                if (mascara == '0) begin
                    rodada_n = 1'b1;
                    estado_n = IDLE;
                end else begin
                    endereco_n = endereco_sel;
                    mascara_n  = mascara & ~bit_menor;
                    ler_n      = 1'b1;
                    estado_n   = LER;
                end
            end
            LER: begin
                estado_n = ESPERA;
            end
            ESPERA: begin
                distancia_n = bus.distancia_in;
                valid_n     = 1'b1;
                estado_n    = ENVIAR;
            end
            ENVIAR: begin
                if (bus.estab_ready_in) begin
                    contador_n = (&contador_q) ? contador_q : contador_q + 1'b1;
                    remover_n  = 1'b1;
                    estado_n   = REMOVER;
                end else begin
                    valid_n = 1'b1;
                end
            end
            REMOVER: begin
                estado_n = SELECIONAR;
            end
            default: begin
                estado_n = IDLE;
            end
        endcase

        ocupado_n = (estado_n != IDLE);
    end

    // Strobes are the registered image of the next state, so each one is high
    // exactly while the FSM sits in its corresponding state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            estado      <= IDLE;
            mascara     <= '0;
            endereco_q  <= '0;
            distancia_q <= '0;
            contador_q  <= '0;
            ler_q       <= 1'b0;
            remover_q   <= 1'b0;
            valid_q     <= 1'b0;
            ocupado_q   <= 1'b0;
            rodada_q    <= 1'b0;
        end else begin
            estado      <= estado_n;
            mascara     <= mascara_n;
            endereco_q  <= endereco_n;
            distancia_q <= distancia_n;
            contador_q  <= contador_n;
            ler_q       <= ler_n;
            remover_q   <= remover_n;
            valid_q     <= valid_n;
            ocupado_q   <= ocupado_n;
            rodada_q    <= rodada_n;
        end
    end

    assign bus.ler_distancia_out          = ler_q;
    assign bus.ler_distancia_endereco_out = endereco_q;
    assign bus.remover_out                = remover_q;
    assign bus.remover_endereco_out       = endereco_q;
    assign bus.estab_valid_out            = valid_q;
    assign bus.estab_endereco_out         = endereco_q;
    assign bus.estab_distancia_out        = distancia_q;
    assign bus.ocupado_out                = ocupado_q;
    assign bus.rodada_fim_out             = rodada_q;
    assign bus.num_estab_out              = contador_q;

endmodule

// File: tb/tb_seletor_aprovados.sv
// Directed bench for seletor_aprovados with a record/removal scoreboard.
module tb_seletor_aprovados;
    localparam int N  = 24;
    localparam int NW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seletor_aprovados_if #(.NUM_ATIVOS(N), .NODE_WIDTH(NW), .DIST_WIDTH(DW)) bus ();

    seletor_aprovados #(.NUM_ATIVOS(N), .NODE_WIDTH(NW), .DIST_WIDTH(DW)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    // Evaluator model: distance is a fixed function of the address being read.
    assign bus.distancia_in = bus.ler_distancia_endereco_out ^ 8'h1C;

    int checks = 0;
    int errors = 0;
    int n_rodada = 0;
    int n_rem = 0;
    logic [15:0] exp_rec[$];
    logic [7:0]  exp_rem[$];

    function automatic logic [7:0] addr_of(int k);
        return 8'(k + 8'h13);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_mask(logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[k]) begin
                exp_rec.push_back({addr_of(k), addr_of(k) ^ 8'h1C});
                exp_rem.push_back(addr_of(k));
            end
        end
    endtask

    task automatic wait_valid();
        int b = 0;
        while (!bus.estab_valid_out && b < 20) begin
            step();
            b++;
        end
        chk("valid_timeout", {31'b0, b < 20}, 32'd1);
    endtask

    task automatic run_round(logic [N-1:0] m, bit iso);
        int b = 0;
        push_mask(m);
        bus.tem_ativo_in = 1'b1;
        bus.aprovados_in = m;
        step();
        bus.aprovados_in = iso ? '1 : '0;
        while (!bus.rodada_fim_out && b < 400) begin
            step();
            b++;
        end
        chk("round_timeout", {31'b0, b < 400}, 32'd1);
        bus.tem_ativo_in = 1'b0;
        bus.aprovados_in = '0;
        chk("queues_drained", exp_rec.size() + exp_rem.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("strobe_exclusive",
                {31'b0, $countones({bus.ler_distancia_out, bus.remover_out, bus.estab_valid_out}) <= 1},
                32'd1);
            if (bus.ler_distancia_out) begin
                chk("ler_expected", {31'b0, exp_rec.size() != 0}, 32'd1);
                if (exp_rec.size() != 0)
                    chk("ler_addr", bus.ler_distancia_endereco_out, exp_rec[0][15:8]);
            end
            if (bus.estab_valid_out && bus.estab_ready_in) begin
                chk("rec_expected", {31'b0, exp_rec.size() != 0}, 32'd1);
                if (exp_rec.size() != 0)
                    chk("rec_payload", {bus.estab_endereco_out, bus.estab_distancia_out},
                        exp_rec.pop_front());
            end
            if (bus.remover_out) begin
                n_rem++;
                chk("rem_expected", {31'b0, exp_rem.size() != 0}, 32'd1);
                if (exp_rem.size() != 0)
                    chk("rem_addr", bus.remover_endereco_out, exp_rem.pop_front());
            end
            if (bus.rodada_fim_out) n_rodada++;
        end
    end

    initial begin
        int r0, m0;
        rst = 1'b1;
        bus.tem_ativo_in   = 1'b0;
        bus.aprovados_in   = '0;
        bus.estab_ready_in = 1'b1;
        for (int k = 0; k < N; k++) bus.enderecos_in[k*NW +: NW] = addr_of(k);
        step();
        step();
        chk("rst_outputs", {bus.ler_distancia_out, bus.remover_out, bus.estab_valid_out,
                            bus.ocupado_out, bus.rodada_fim_out}, 32'd0);
        chk("rst_count", bus.num_estab_out, 32'd0);
        rst = 1'b0;
        step();

        // Single node with exact cycle timing.
        push_mask(24'h000004);
        bus.tem_ativo_in = 1'b1;
        bus.aprovados_in = 24'h000004;
        step();
        chk("c1_ocupado", bus.ocupado_out, 32'd1);
        chk("c1_ler", bus.ler_distancia_out, 32'd0);
        bus.tem_ativo_in = 1'b0;
        bus.aprovados_in = '0;
        step();
        chk("c2_ler", bus.ler_distancia_out, 32'd1);
        chk("c2_ler_addr", bus.ler_distancia_endereco_out, 32'h15);
        step();
        chk("c3_ler_low", bus.ler_distancia_out, 32'd0);
        chk("c3_valid_low", bus.estab_valid_out, 32'd0);
        step();
        chk("c4_valid", bus.estab_valid_out, 32'd1);
        chk("c4_payload", {bus.estab_endereco_out, bus.estab_distancia_out}, 32'h1509);
        step();
        chk("c5_remover", bus.remover_out, 32'd1);
        chk("c5_rem_addr", bus.remover_endereco_out, 32'h15);
        chk("c5_valid_low", bus.estab_valid_out, 32'd0);
        step();
        chk("c6_rodada_low", bus.rodada_fim_out, 32'd0);
        step();
        chk("c7_rodada", bus.rodada_fim_out, 32'd1);
        chk("c7_ocupado", bus.ocupado_out, 32'd0);
        chk("c7_count", bus.num_estab_out, 32'd1);
        step();
        chk("c8_rodada_low", bus.rodada_fim_out, 32'd0);

        // Multiple nodes: slots 0, 8, 23.
        r0 = n_rodada;
        m0 = n_rem;
        run_round(24'h800101, 1'b0);
        step();
        chk("multi_count", bus.num_estab_out, 32'd4);
        chk("multi_removes", n_rem - m0, 32'd3);
        chk("multi_rodada", n_rodada - r0, 32'd1);

        // Backpressure on slot 5.
        push_mask(24'h000020);
        bus.estab_ready_in = 1'b0;
        bus.tem_ativo_in   = 1'b1;
        bus.aprovados_in   = 24'h000020;
        step();
        bus.tem_ativo_in = 1'b0;
        bus.aprovados_in = '0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", bus.estab_valid_out, 32'd1);
            chk("bp_payload", {bus.estab_endereco_out, bus.estab_distancia_out}, 32'h1804);
            chk("bp_no_remove", bus.remover_out, 32'd0);
        end
        bus.estab_ready_in = 1'b1;
        step();
        chk("bp_remove", bus.remover_out, 32'd1);
        chk("bp_valid_low", bus.estab_valid_out, 32'd0);
        repeat (4) step();
        chk("bp_count", bus.num_estab_out, 32'd5);
        chk("bp_idle", bus.ocupado_out, 32'd0);

        // Snapshot isolation: mask floods to all-ones after capture.
        run_round(24'h000030, 1'b1);
        step();
        chk("iso_count", bus.num_estab_out, 32'd7);

        // Reset while a record is pending in ENVIAR.
        push_mask(24'h000008);
        bus.estab_ready_in = 1'b0;
        bus.tem_ativo_in   = 1'b1;
        bus.aprovados_in   = 24'h000008;
        step();
        bus.tem_ativo_in = 1'b0;
        bus.aprovados_in = '0;
        wait_valid();
        rst = 1'b1;
        step();
        chk("mr_valid", bus.estab_valid_out, 32'd0);
        chk("mr_ocupado", bus.ocupado_out, 32'd0);
        chk("mr_count", bus.num_estab_out, 32'd0);
        chk("mr_remove", bus.remover_out, 32'd0);
        exp_rec.delete();
        exp_rem.delete();
        rst = 1'b0;
        bus.estab_ready_in = 1'b1;
        m0 = n_rem;
        repeat (6) step();
        chk("mr_no_remove_after", n_rem - m0, 32'd0);
        chk("mr_still_idle", bus.ocupado_out, 32'd0);

        // Idle guard.
        bus.tem_ativo_in = 1'b0;
        bus.aprovados_in = '1;
        repeat (4) begin
            step();
            chk("guard_no_ativo", {bus.ocupado_out, bus.ler_distancia_out}, 32'd0);
        end
        bus.tem_ativo_in = 1'b1;
        bus.aprovados_in = '0;
        repeat (4) begin
            step();
            chk("guard_no_aprov", {bus.ocupado_out, bus.ler_distancia_out}, 32'd0);
        end
        bus.tem_ativo_in = 1'b0;

        // Saturation: 255 handshakes, then one more.
        for (int i = 0; i < 10; i++) run_round('1, 1'b0);
        run_round(24'h007FFF, 1'b0);
        step();
        chk("sat_255", bus.num_estab_out, 32'hFF);
        run_round(24'h000004, 1'b0);
        step();
        chk("sat_hold", bus.num_estab_out, 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
